bp_zynq_multicore_cfg_sequencer: RTL and testbench

//  Per-core configuration shadow and boot sequencer for multicore zynq-parrot builds.
//  It holds freeze, NPC and I$/D$ mode for num_core_p cores and accepts single-core or

---
 rtl/bp_zynq_multicore_cfg_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_bp_zynq_multicore_cfg_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_zynq_multicore_cfg_sequencer.sv
// ----------------------------------------------------------------------------
// bp_zynq_multicore_cfg_sequencer
//
// Per-core configuration shadow and boot sequencer. It holds freeze, NPC and
// I$/D$ mode for every core, and accepts single-core or broadcast writes from
// the host command decoder. A broadcast boot releases freeze one core at a
// time, stagger_cycles_p apart, so the cores' first fetches do not hit the
// L2/DRAM path together.
//
// Ports
//   clk_i, reset_i    clock, synchronous active-high reset
//   cmd_v_i           command valid
//   cmd_ready_o       command ready (transfer = cmd_v_i & cmd_ready_o)
//   cmd_op_i          0 NPC, 1 I$ mode, 2 D$ mode, 3 freeze, 4 boot, 5-7 illegal
//   cmd_bcast_i       1 = all cores, 0 = cmd_core_i only
//   cmd_core_i        target core for non-broadcast commands
//   cmd_data_i        write data; low bits used
//   freeze_o          per-core freeze
//   npc_o             per-core NPC, core k at [k*vaddr_width_p +: vaddr_width_p]
//   icache_mode_o     per-core I$ mode, core k at [k*mode_width_p +: mode_width_p]
//   dcache_mode_o     per-core D$ mode, same packing
//   boot_done_o       every core has been released by a boot command
//   err_o             one-cycle pulse, the cycle after a rejected command
// ----------------------------------------------------------------------------
module bp_zynq_multicore_cfg_sequencer #(
    parameter int          num_core_p       = 4,
    parameter int          vaddr_width_p    = 39,
    parameter int          mode_width_p     = 2,
    parameter logic [63:0] boot_pc_p        = 64'h8000_0000,
    parameter int          stagger_cycles_p = 16,
    localparam int core_width_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1,
    localparam int cnt_width_lp  = (stagger_cycles_p > 1) ? $clog2(stagger_cycles_p) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  cmd_v_i,
    output logic                                  cmd_ready_o,
    input  logic [2:0]                            cmd_op_i,
    input  logic                                  cmd_bcast_i,
    input  logic [core_width_lp-1:0]              cmd_core_i,
    input  logic [63:0]                           cmd_data_i,
    output logic [num_core_p-1:0]                 freeze_o,
    output logic [num_core_p*vaddr_width_p-1:0]   npc_o,
    output logic [num_core_p*mode_width_p-1:0]    icache_mode_o,
    output logic [num_core_p*mode_width_p-1:0]    dcache_mode_o,
    output logic                                  boot_done_o,
    output logic                                  err_o
);

    typedef enum logic [0:0] {
        e_idle = 1'b0,
        e_boot = 1'b1
    } state_e;

    localparam logic [2:0] op_npc    = 3'd0;
    localparam logic [2:0] op_icache = 3'd1;
    localparam logic [2:0] op_dcache = 3'd2;
    localparam logic [2:0] op_freeze = 3'd3;
    localparam logic [2:0] op_boot   = 3'd4;

    state_e                    state_reg, state_next;
    logic [core_width_lp-1:0]  idx_reg, idx_next;
    logic [cnt_width_lp-1:0]   cnt_reg, cnt_next;
    logic                      boot_done_reg, boot_done_next;
    logic                      err_reg, err_next;
    logic                      ready_reg, ready_next;

    logic                      handshake;
    logic                      core_ok;
    logic                      any_target_unfrozen;
    logic [num_core_p-1:0]     tgt_mask;
    logic [num_core_p-1:0]     slot_mask;
    logic [num_core_p-1:0]     freeze_vec;
    logic [num_core_p-1:0]     freeze_set_mask;
    logic [num_core_p-1:0]     unfreeze_mask;
    logic                      wr_npc, wr_icache, wr_dcache;

    // Only the low bits of the command data reach a field.
    logic unused_data;
    assign unused_data = ^cmd_data_i;

    assign handshake           = cmd_v_i & ready_reg;
    assign core_ok             = cmd_bcast_i |
                                 ({1'b0, cmd_core_i} < (core_width_lp+1)'(num_core_p));
    assign any_target_unfrozen = |(tgt_mask & ~freeze_vec);

    // ------------------------------------------------------------------
    // Per-core shadow registers
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < num_core_p; gi++) begin : g_core
            logic                     freeze_reg;
            logic [vaddr_width_p-1:0] npc_reg;
            logic [mode_width_p-1:0]  icache_reg;
            logic [mode_width_p-1:0]  dcache_reg;

            assign tgt_mask[gi]  = cmd_bcast_i | (cmd_core_i == core_width_lp'(gi));
            assign slot_mask[gi] = (idx_reg == core_width_lp'(gi));

            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    freeze_reg <= 1'b1;
                    npc_reg    <= boot_pc_p[vaddr_width_p-1:0];
                    icache_reg <= '0;
                    dcache_reg <= '0;
                end else begin
                    if (freeze_set_mask[gi]) begin
                        freeze_reg <= 1'b1;
                    end else if (unfreeze_mask[gi]) begin
                        freeze_reg <= 1'b0;
                    end
                    if (wr_npc && tgt_mask[gi]) begin
                        npc_reg <= cmd_data_i[vaddr_width_p-1:0];
                    end
                    if (wr_icache && tgt_mask[gi]) begin
                        icache_reg <= cmd_data_i[mode_width_p-1:0];
                    end
                    if (wr_dcache && tgt_mask[gi]) begin
                        dcache_reg <= cmd_data_i[mode_width_p-1:0];
                    end
                end
            end

            assign freeze_vec[gi]                                      = freeze_reg;
            assign npc_o[gi*vaddr_width_p +: vaddr_width_p]            = npc_reg;
            assign icache_mode_o[gi*mode_width_p +: mode_width_p]      = icache_reg;
            assign dcache_mode_o[gi*mode_width_p +: mode_width_p]      = dcache_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Command decode and boot sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        cnt_next        = cnt_reg;
        boot_done_next  = boot_done_reg;
        err_next        = 1'b0;
        freeze_set_mask = '0;
        unfreeze_mask   = '0;
        wr_npc          = 1'b0;
        wr_icache       = 1'b0;
        wr_dcache       = 1'b0;

        case (state_reg)
            e_idle: begin
                if (handshake) begin
                    if (!core_ok) begin
                        err_next = 1'b1;
                    end else begin
                        case (cmd_op_i)
                            op_npc, op_icache, op_dcache: begin
                                // A running core must never see its config
                                // change underneath it: drop the whole write.
                                if (any_target_unfrozen) begin
                                    err_next = 1'b1;
                                end else begin
                                    wr_npc    = (cmd_op_i == op_npc);
                                    wr_icache = (cmd_op_i == op_icache);
                                    wr_dcache = (cmd_op_i == op_dcache);
                                end
                            end
                            op_freeze: begin
                                freeze_set_mask = tgt_mask;
                                boot_done_next  = 1'b0;
                            end
                            op_boot: begin
                                if (!cmd_bcast_i) begin
                                    unfreeze_mask  = tgt_mask;
                                    boot_done_next = ~|(freeze_vec & ~tgt_mask);
                                end else begin
                                    // Core 0's slot is taken on the handshake
                                    // edge itself, so it is running in H+1 and
                                    // core k in H+1+k*stagger_cycles_p.
                                    unfreeze_mask = num_core_p'(1);
                                    if (num_core_p == 1) begin
                                        boot_done_next = 1'b1;
                                    end else begin
                                        // boot_done stays low until the last
                                        // core has been released again.
                                        boot_done_next = 1'b0;
                                        state_next     = e_boot;
                                        idx_next       = core_width_lp'(1);
                                        cnt_next       = cnt_width_lp'(stagger_cycles_p - 1);
                                    end
                                end
                            end
                            default: begin
                                err_next = 1'b1;
                            end
                        endcase
                    end
                end
            end

            e_boot: begin
                if (cnt_reg == '0) begin
                    // Slots of already-running cores are still consumed so
                    // the release schedule never depends on prior state.
                    unfreeze_mask = slot_mask;
                    if (idx_reg == core_width_lp'(num_core_p - 1)) begin
                        state_next     = e_idle;
                        boot_done_next = 1'b1;
                    end else begin
                        idx_next = idx_reg + core_width_lp'(1);
                        cnt_next = cnt_width_lp'(stagger_cycles_p - 1);
                    end
                end else begin
                    cnt_next = cnt_reg - cnt_width_lp'(1);
                end
            end

            default: begin
                state_next = e_idle;
            end
        endcase

        ready_next = (state_next == e_idle);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg     <= e_idle;
            idx_reg       <= '0;
            cnt_reg       <= '0;
            boot_done_reg <= 1'b0;
            err_reg       <= 1'b0;
            ready_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            cnt_reg       <= cnt_next;
            boot_done_reg <= boot_done_next;
            err_reg       <= err_next;
            ready_reg     <= ready_next;
        end
    end

    assign cmd_ready_o = ready_reg;
    assign freeze_o    = freeze_vec;
    assign boot_done_o = boot_done_reg;
    assign err_o       = err_reg;

endmodule

// File: tb/tb_bp_zynq_multicore_cfg_sequencer.sv
// ----------------------------------------------------------------------------
// Testbench for bp_zynq_multicore_cfg_sequencer.
// Main instance: 4 cores, stagger 16. Small instance: 1 core, stagger 1, used
// for the single-core boot case and an out-of-range core index.
// Expected values come from a per-core array model updated by the command
// rules; broadcast boot is checked against the release-time formula.
// ----------------------------------------------------------------------------
module tb_bp_zynq_multicore_cfg_sequencer;

    localparam int NC = 4;
    localparam int ST = 16;
    localparam int VW = 39;
    localparam int MW = 2;
    localparam logic [VW-1:0] PC = 39'h80000000;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_v;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic              cmd_bcast;
    logic [1:0]        cmd_core;
    logic [63:0]       cmd_data;
    logic [NC-1:0]     freeze;
    logic [NC*VW-1:0]  npc;
    logic [NC*MW-1:0]  icm;
    logic [NC*MW-1:0]  dcm;
    logic              boot_done;
    logic              err;

    logic              c_v;
    logic              c_ready;
    logic [2:0]        c_op;
    logic              c_bcast;
    logic [0:0]        c_core;
    logic [63:0]       c_data;
    logic [0:0]        c_freeze;
    logic [VW-1:0]     c_npc;
    logic [MW-1:0]     c_icm;
    logic [MW-1:0]     c_dcm;
    logic              c_bd;
    logic              c_err;

    int checks = 0;
    int fails  = 0;

    // Reference model
    bit              m_fr  [NC];
    logic [VW-1:0]   m_npc [NC];
    logic [MW-1:0]   m_im  [NC];
    logic [MW-1:0]   m_dm  [NC];
    bit              m_bd;

    always #5 clk = ~clk;

    bp_zynq_multicore_cfg_sequencer #(
        .num_core_p(NC), .vaddr_width_p(VW), .mode_width_p(MW),
        .boot_pc_p(64'h8000_0000), .stagger_cycles_p(ST)
    ) dut (
        .clk_i(clk), .reset_i(reset), .cmd_v_i(cmd_v), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_bcast_i(cmd_bcast), .cmd_core_i(cmd_core),
        .cmd_data_i(cmd_data), .freeze_o(freeze), .npc_o(npc),
        .icache_mode_o(icm), .dcache_mode_o(dcm), .boot_done_o(boot_done),
        .err_o(err)
    );

    bp_zynq_multicore_cfg_sequencer #(
        .num_core_p(1), .vaddr_width_p(VW), .mode_width_p(MW),
        .boot_pc_p(64'h8000_0000), .stagger_cycles_p(1)
    ) dut_one (
        .clk_i(clk), .reset_i(reset), .cmd_v_i(c_v), .cmd_ready_o(c_ready),
        .cmd_op_i(c_op), .cmd_bcast_i(c_bcast), .cmd_core_i(c_core),
        .cmd_data_i(c_data), .freeze_o(c_freeze), .npc_o(c_npc),
        .icache_mode_o(c_icm), .dcache_mode_o(c_dcm), .boot_done_o(c_bd),
        .err_o(c_err)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] exp_freeze();
        logic [255:0] r = '0;
        for (int k = 0; k < NC; k++) r[k] = m_fr[k];
        return r;
    endfunction

    function automatic logic [255:0] exp_npc();
        logic [255:0] r = '0;
        for (int k = 0; k < NC; k++) r[k*VW +: VW] = m_npc[k];
        return r;
    endfunction

    function automatic logic [255:0] exp_mode(input bit dside);
        logic [255:0] r = '0;
        for (int k = 0; k < NC; k++) r[k*MW +: MW] = dside ? m_dm[k] : m_im[k];
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NC; k++) begin
            m_fr[k]  = 1'b1;
            m_npc[k] = PC;
            m_im[k]  = '0;
            m_dm[k]  = '0;
        end
        m_bd = 1'b0;
    endtask

    task automatic check_all(input string tag, input bit exp_err, input bit exp_ready);
        chk({tag, ".freeze"}, freeze, exp_freeze());
        chk({tag, ".npc"}, npc, exp_npc());
        chk({tag, ".icache"}, icm, exp_mode(1'b0));
        chk({tag, ".dcache"}, dcm, exp_mode(1'b1));
        chk({tag, ".boot_done"}, boot_done, 256'(m_bd));
        chk({tag, ".err"}, err, 256'(exp_err));
        chk({tag, ".ready"}, cmd_ready, 256'(exp_ready));
    endtask

    // Called at a negedge; returns #1 after the handshake edge (cycle H).
    task automatic handshake(input logic [2:0] op, input bit b, input logic [1:0] core,
                             input logic [63:0] data);
        chk("ready_before_cmd", cmd_ready, 256'(1));
        cmd_v = 1'b1; cmd_op = op; cmd_bcast = b; cmd_core = core; cmd_data = data;
        @(posedge clk);
        #1;
        cmd_v = 1'b0;
    endtask

    // Any command other than a broadcast boot.
    task automatic send(input logic [2:0] op, input bit b, input logic [1:0] core,
                        input logic [63:0] data);
        bit tgt [NC];
        bit anyunf = 1'b0;
        bit err_e  = 1'b0;
        bit all0   = 1'b1;
        handshake(op, b, core, data);
        for (int k = 0; k < NC; k++) begin
            tgt[k] = b || (int'(core) == k);
            if (tgt[k] && !m_fr[k]) anyunf = 1'b1;
        end
        case (op)
            3'd0, 3'd1, 3'd2: begin
                if (anyunf) err_e = 1'b1;
                else for (int k = 0; k < NC; k++) if (tgt[k]) begin
                    if (op == 3'd0) m_npc[k] = data[VW-1:0];
                    if (op == 3'd1) m_im[k]  = data[MW-1:0];
                    if (op == 3'd2) m_dm[k]  = data[MW-1:0];
                end
            end
            3'd3: begin
                for (int k = 0; k < NC; k++) if (tgt[k]) m_fr[k] = 1'b1;
                m_bd = 1'b0;
            end
            3'd4: begin
                m_fr[core] = 1'b0;
                for (int k = 0; k < NC; k++) if (m_fr[k]) all0 = 1'b0;
                m_bd = all0;
            end
            default: err_e = 1'b1;
        endcase
        @(negedge clk);
        $display("cmd op=%0d bcast=%0d core=%0d data=%0h err=%0d freeze=%b",
                 op, b, core, data, err, freeze);
        check_all($sformatf("op%0d_b%0d_c%0d", op, b, core), err_e, 1'b1);
        @(negedge clk);
        chk("err_single_pulse", err, 256'(0));
    endtask

    // Broadcast boot; abort_at > 0 asserts reset in cycle H+abort_at.
    task automatic boot_all(input int abort_at);
        bit            fr0 [NC];
        logic [NC-1:0] efr;
        int            last = 1 + (NC - 1) * ST;
        fr0 = m_fr;
        handshake(3'd4, 1'b1, 2'($urandom), {$urandom, $urandom});
        $display("cmd bcast boot abort_at=%0d", abort_at);
        for (int j = 1; j <= last; j++) begin
            @(negedge clk);
            for (int k = 0; k < NC; k++) efr[k] = fr0[k] && (j < 1 + k * ST);
            chk($sformatf("boot_freeze_H+%0d", j), freeze, 256'(efr));
            chk($sformatf("boot_done_H+%0d", j), boot_done, 256'(j >= last));
            chk($sformatf("boot_ready_H+%0d", j), cmd_ready, 256'(j >= last));
            chk($sformatf("boot_err_H+%0d", j), err, 256'(0));
            // A command offered while busy must be ignored entirely.
            if (j == 5) begin
                cmd_v = 1'b1; cmd_op = 3'd3; cmd_bcast = 1'b1;
            end
            if (j == 6) cmd_v = 1'b0;
            if (j == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                model_reset();
                check_all("reset_mid_boot", 1'b0, 1'b0);
                reset = 1'b0;
                @(negedge clk);
                chk("ready_after_reset", cmd_ready, 256'(1));
                return;
            end
        end
        for (int k = 0; k < NC; k++) m_fr[k] = 1'b0;
        m_bd = 1'b1;
        chk("boot_npc_kept", npc, exp_npc());
    endtask

    task automatic c_send(input logic [2:0] op, input bit b, input logic [0:0] core,
                          input logic [63:0] data);
        c_v = 1'b1; c_op = op; c_bcast = b; c_core = core; c_data = data;
        @(posedge clk);
        #1;
        c_v = 1'b0;
        @(negedge clk);
        $display("one-core cmd op=%0d bcast=%0d core=%0d err=%0d freeze=%b",
                 op, b, core, c_err, c_freeze);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cmd_v = 1'b0; cmd_op = '0; cmd_bcast = 1'b0;
        cmd_core = '0; cmd_data = '0;
        c_v = 1'b0; c_op = '0; c_bcast = 1'b0; c_core = '0; c_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("in_reset", 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check_all("after_reset", 1'b0, 1'b1);

        // Broadcast NPC then staggered broadcast boot.
        send(3'd0, 1'b1, 2'd0, 64'h8000_1000);
        boot_all(0);

        // Writes to running cores are rejected; refreeze all, then D$ bcast.
        send(3'd1, 1'b1, 2'd0, 64'h3);
        send(3'd3, 1'b1, 2'd0, 64'h0);
        send(3'd2, 1'b1, 2'd0, 64'h1);

        // Single-core boot of core 2; write to it drops, write to core 1 lands.
        send(3'd4, 1'b0, 2'd2, 64'h0);
        send(3'd0, 1'b0, 2'd2, 64'h1234);
        send(3'd0, 1'b0, 2'd1, 64'h1234);
        send(3'd0, 1'b1, 2'd0, 64'h5555);

        // Illegal opcodes.
        send(3'd6, 1'b0, 2'd1, 64'hFF);
        send(3'd5, 1'b1, 2'd0, 64'hFF);

        // Reset during a broadcast boot.
        send(3'd3, 1'b1, 2'd0, 64'h0);
        boot_all(20);

        // Single-core instance.
        chk("one.reset_freeze", c_freeze, 256'(1));
        chk("one.reset_npc", c_npc, 256'(PC));
        c_send(3'd1, 1'b0, 1'b1, 64'h3);
        chk("one.bad_core_err", c_err, 256'(1));
        chk("one.bad_core_icache", c_icm, 256'(0));
        c_send(3'd1, 1'b0, 1'b0, 64'h3);
        chk("one.icache_err", c_err, 256'(0));
        chk("one.icache", c_icm, 256'(3));
        c_send(3'd4, 1'b1, 1'b0, 64'h0);
        chk("one.boot_freeze", c_freeze, 256'(0));
        chk("one.boot_done", c_bd, 256'(1));
        chk("one.boot_ready", c_ready, 256'(1));
        c_send(3'd2, 1'b1, 1'b0, 64'h1);
        chk("one.run_write_err", c_err, 256'(1));
        chk("one.run_write_dcache", c_dcm, 256'(0));
        @(negedge clk);

        // Randomized command stream against the model.
        for (int i = 0; i < 40; i++) begin
            int          r    = int'($urandom_range(0, 11));
            logic [1:0]  core = 2'($urandom);
            logic [63:0] data = {$urandom, $urandom};
            bit          b    = 1'($urandom);
            case (r)
                0, 1, 2:  send(3'(r), b, core, data);
                3, 4:     send(3'd3, b, core, data);
                5:        send(3'd4, 1'b0, core, data);
                6:        send(3'($urandom_range(5, 7)), b, core, data);
                7:        boot_all(0);
                default:  send(3'($urandom_range(0, 2)), 1'b0, core, data);
            endcase
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
